// File: rtl/even_seq_checker.sv
// Lock/error checker for a +2 even-number generator stream (IDLE -> SYNC -> LOCKED).
// Optional BCD view of last_value is enabled by defining EVEN_SEQ_CHECKER_BCD_EN.
module even_seq_checker #(
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [3:0]       sample,
    input  logic             resync,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
`ifdef EVEN_SEQ_CHECKER_BCD_EN
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units,
`endif
    output logic [3:0]       last_value
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0]       LOCK_RUN = 3'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ONE      = ERR_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       run;
    logic [2:0]       run_nxt;
    logic [3:0]       last_nxt;
    logic [3:0]       expected;
    logic             err_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic [ERR_W-1:0] wrap_count_nxt;

    // 4-bit arithmetic makes 14 -> 0 a legal step.
    assign expected = last_value + 4'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        run_nxt        = run;
        last_nxt       = last_value;
        err_nxt        = 1'b0;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;

        if (resync) begin
            state_nxt = IDLE;
            run_nxt   = 3'd0;
        end else if (sample_valid) begin
            if (sample[0]) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                run_nxt   = 3'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        last_nxt  = sample;
                        run_nxt   = 3'd0;
                        state_nxt = SYNC;
                    end
                    SYNC: begin
                        last_nxt = sample;
                        if (sample == expected) begin
                            run_nxt = run + 3'd1;
                            if ((run + 3'd1) == LOCK_RUN) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            run_nxt = 3'd0;
                        end
                    end
                    LOCKED: begin
                        last_nxt = sample;
                        if (sample == expected) begin
                            if (last_value == 4'd14) begin
                                wrap_count_nxt = wrap_count + ONE;
                            end
                        end else begin
                            err_nxt   = 1'b1;
                            run_nxt   = 3'd0;
                            state_nxt = SYNC;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        run_nxt   = 3'd0;
                    end
                endcase
            end

            // Count saturates but the pulse still reports every error.
            if (err_nxt && (err_count != ERR_MAX)) begin
                err_count_nxt = err_count + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 3'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            last_value <= 4'd0;
        end else begin
            run        <= run_nxt;
            locked     <= (state_nxt == LOCKED);
            err_pulse  <= err_nxt;
            err_count  <= err_count_nxt;
            wrap_count <= wrap_count_nxt;
            last_value <= last_nxt;
        end
    end

`ifdef EVEN_SEQ_CHECKER_BCD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_tens  <= 4'd0;
            bcd_units <= 4'd0;
        end else if (last_nxt >= 4'd10) begin
            bcd_tens  <= 4'd1;
            bcd_units <= last_nxt - 4'd10;
        end else begin
            bcd_tens  <= 4'd0;
            bcd_units <= last_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_even_seq_checker.sv
// Randomized self-checking bench for even_seq_checker against a rule-level reference model.
module tb_even_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [3:0] sample;
    logic       resync;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [3:0] last_value;
`ifdef EVEN_SEQ_CHECKER_BCD_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    even_seq_checker #(.LOCK_CNT(2), .ERR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .resync       (resync),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .wrap_count   (wrap_count),
`ifdef EVEN_SEQ_CHECKER_BCD_EN
        .bcd_tens     (bcd_tens),
        .bcd_units    (bcd_units),
`endif
        .last_value   (last_value)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=waiting for first even, 1=counting good steps, 2=locked.
    int m_mode = 0;
    int m_run  = 0;
    int m_last = 0;
    int m_err  = 0;
    int m_errc = 0;
    int m_wrap = 0;

    always @(posedge clk or posedge rst) begin
        int s;
        int good;
        if (rst) begin
            m_mode <= 0; m_run <= 0; m_last <= 0;
            m_err  <= 0; m_errc <= 0; m_wrap <= 0;
        end else begin
            s    = int'(sample);
            good = (s == (m_last + 2) % 16) ? 1 : 0;
            m_err <= 0;
            if (resync) begin
                m_mode <= 0;
                m_run  <= 0;
            end else if (sample_valid) begin
                if (s % 2 == 1) begin
                    m_err  <= 1;
                    m_errc <= (m_errc >= 255) ? 255 : m_errc + 1;
                    m_mode <= 0;
                    m_run  <= 0;
                end else if (m_mode == 0) begin
                    m_last <= s;
                    m_run  <= 0;
                    m_mode <= 1;
                end else if (m_mode == 1) begin
                    m_last <= s;
                    if (good == 1) begin
                        m_run <= m_run + 1;
                        if (m_run + 1 >= 2) m_mode <= 2;
                    end else begin
                        m_run <= 0;
                    end
                end else begin
                    m_last <= s;
                    if (good == 1) begin
                        if (m_last == 14 && s == 0) m_wrap <= (m_wrap + 1) % 256;
                    end else begin
                        m_err  <= 1;
                        m_errc <= (m_errc >= 255) ? 255 : m_errc + 1;
                        m_run  <= 0;
                        m_mode <= 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("locked",     32'(locked),     (m_mode == 2) ? 32'd1 : 32'd0);
        chk("err_pulse",  32'(err_pulse),  32'(m_err));
        chk("err_count",  32'(err_count),  32'(m_errc));
        chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
        chk("last_value", 32'(last_value), 32'(m_last));
`ifdef EVEN_SEQ_CHECKER_BCD_EN
        chk("bcd_tens",   32'(bcd_tens),   32'(m_last / 10));
        chk("bcd_units",  32'(bcd_units),  32'(m_last % 10));
`endif
    end

    // Called at a falling edge; returns at the next falling edge with outputs updated.
    task automatic step(input logic v, input logic [3:0] s, input logic r);
        sample_valid = v;
        sample       = s;
        resync       = r;
        @(negedge clk);
        sample_valid = 1'b0;
        resync       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] val;
        int         r;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = 4'd0;
        resync       = 1'b0;
        do_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_errc",   32'(err_count), 32'd0);
        chk("rst_last",   32'(last_value), 32'd0);

        step(1, 4'd4, 0);
        step(1, 4'd6, 0);
        chk("lock_early", 32'(locked), 32'd0);
        step(1, 4'd8, 0);
        chk("lock_on8", 32'(locked), 32'd1);
        chk("lock_errc", 32'(err_count), 32'd0);

        step(1, 4'd10, 0);
        step(1, 4'd12, 0);
        step(1, 4'd14, 0);
        step(1, 4'd0, 0);
        chk("wrap_one", 32'(wrap_count), 32'd1);
        chk("wrap_nopulse", 32'(err_pulse), 32'd0);
        step(1, 4'd2, 0);
        step(1, 4'd4, 0);

        step(1, 4'd10, 0);
        chk("break_pulse",  32'(err_pulse), 32'd1);
        chk("break_errc",   32'(err_count), 32'd1);
        chk("break_locked", 32'(locked), 32'd0);
        step(1, 4'd12, 0);
        chk("break_pulse_end", 32'(err_pulse), 32'd0);
        step(1, 4'd14, 0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_wrap", 32'(wrap_count), 32'd1);

        step(1, 4'd5, 0);
        chk("odd_pulse", 32'(err_pulse), 32'd1);
        chk("odd_last",  32'(last_value), 32'd14);
        chk("odd_errc",  32'(err_count), 32'd2);

        step(1, 4'd0, 0);
        step(1, 4'd2, 0);
        step(1, 4'd4, 1);
        chk("resync_last", 32'(last_value), 32'd2);
        step(1, 4'd8, 0);
        chk("resync_idle", 32'(last_value), 32'd8);
        chk("resync_noerr", 32'(err_count), 32'd2);
        step(1, 4'd10, 0);
        step(1, 4'd12, 0);
        chk("lock2", 32'(locked), 32'd1);
`ifdef EVEN_SEQ_CHECKER_BCD_EN
        chk("bcd12_tens",  32'(bcd_tens), 32'd1);
        chk("bcd12_units", 32'(bcd_units), 32'd2);
`endif
        step(0, 4'd0, 1);
        chk("resync_unlock", 32'(locked), 32'd0);
        chk("resync_keep", 32'(last_value), 32'd12);

        step(1, 4'd6, 0);
        step(1, 4'd8, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_errc",   32'(err_count), 32'd0);
        chk("async_wrap",   32'(wrap_count), 32'd0);
        chk("async_last",   32'(last_value), 32'd0);
`ifdef EVEN_SEQ_CHECKER_BCD_EN
        chk("async_bcd_units", 32'(bcd_units), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'd6, 0);
        chk("post_rst_last", 32'(last_value), 32'd6);
        chk("post_rst_unlocked", 32'(locked), 32'd0);
        step(1, 4'd8, 0);
        step(1, 4'd10, 0);
        chk("post_rst_lock", 32'(locked), 32'd1);

        prev = 4'd10;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      val = prev + 4'd2;
            else if (r < 80) val = 4'($urandom_range(0, 7) * 2 + 1);
            else             val = 4'($urandom_range(0, 7) * 2);
            if ($urandom_range(0, 99) < 85) begin
                step(1, val, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
                if (val[0] == 1'b0) prev = val;
            end else begin
                step(0, val, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
            end
        end

        do_reset();
        step(1, 4'd0, 0);
        step(1, 4'd2, 0);
        step(1, 4'd4, 0);
        chk("roll_lock", 32'(locked), 32'd1);
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 8; j++) step(1, 4'(6 + 2 * j), 0);
        end
        chk("roll_zero", 32'(wrap_count), 32'd0);
        chk("roll_locked", 32'(locked), 32'd1);
        for (int j = 0; j < 8; j++) step(1, 4'(6 + 2 * j), 0);
        chk("roll_one", 32'(wrap_count), 32'd1);

        for (int k = 0; k < 260; k++) step(1, 4'd5, 0);
        chk("sat_errc", 32'(err_count), 32'd255);
        chk("sat_pulse", 32'(err_pulse), 32'd1);
        chk("sat_last", 32'(last_value), 32'd4);

        step(0, 4'd0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
